seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range >= 4.
REQ-002 Parameter GAP_CYC, default 1000, blanking cycles at the start of each slot; legal range 1 to REFRESH_DIV-2.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  scan enable; low forces display off and restarts the scan.
REQ-006 digit0, digit1, digit2, digit3  input  4 each  digit codes, digit0 rightmost; 0-9 BCD, 10-15 dash.
REQ-007 dp_en  input  4  decimal point request per digit; bit k belongs to digitk.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 an  output  4  active-low anode select; bit k drives digit k.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low decimal point.

Function
REQ-012 Slot counter cnt SHALL count 0 to REFRESH_DIV-1 and wrap to 0; slot index idx SHALL advance 0,1,2,3,0 on each wrap.
REQ-013 FSM states SHALL be OFF, GAP, SHOW; the state SHALL move OFF->GAP when enable=1, GAP->SHOW at cnt==GAP_CYC-1, SHOW->GAP at cnt==REFRESH_DIV-1, and any state->OFF when enable=0.
REQ-014 At cnt==0, the code of digit[idx], dp_en[idx] and the blank decision SHALL be snapshotted; input changes mid-slot SHALL NOT affect the current slot.
REQ-015 Outputs SHALL be registered, one cycle latency: the outputs for cycle n+1 reflect the state and snapshot of cycle n.
REQ-016 In GAP or OFF: an=4'b1111, seg=7'b1111111, dp=1.
REQ-017 In SHOW: an SHALL have only bit idx low; seg SHALL be the decoded snapshot; dp SHALL be the inverse of the snapshotted dp_en bit.
REQ-018 Decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10-15=0111111.
REQ-019 When blank_lz=1, digit k (k=3,2,1) SHALL be blanked (seg=1111111, an still asserted) when its code and every higher digit's code are 0; digit0 SHALL never be blanked.
REQ-020 dp SHALL be driven per REQ-017 even on a blanked digit.
REQ-021 When enable falls, the next edge SHALL set cnt=0, idx=0 and state OFF; outputs SHALL be off one cycle later.
REQ-022 When enable rises, the first GAP cycle SHALL have cnt=0, idx=0.
REQ-023 More than one an bit SHALL never be low in any cycle.

Reset
REQ-024 When reset=1 at an edge, the block SHALL set state=OFF, cnt=0, idx=0, an=4'b1111, seg=7'b1111111, dp=1 and clear the snapshot to 0.
REQ-025 reset SHALL take priority over enable; asserting it mid-slot SHALL abort the slot with no partial-digit output after the edge.

Structure
REQ-026 Package seg7_pkg SHALL hold the state enum, segment pattern constants (digits, DASH, BLANK) and the width of the idx type.
REQ-027 A combinational sub-module seg7_decoder (4-bit code in, 7-bit active-low segments out) SHALL implement REQ-018; scan, blanking and FSM logic SHALL reside in seg7_scan_driver.

Verification (REFRESH_DIV=8, GAP_CYC=2, enable=1 from cycle 0 after reset release)
REQ-028 Reset for 3 cycles with digit0..3 = 1,2,3,4 and blank_lz=0 -> outputs off through cycle 2; an=1110 with seg=1111001 on cycles 3-8; off on cycles 9-10; an=1101 with seg=0100100 on cycles 11-16.
REQ-029 Digits 0,0,7,0 (digit3..digit0 = 0,0,7,0) with blank_lz=1 -> digit3 and digit2 slots show seg=1111111 with their an bit low; digit1 shows 1111000; digit0 shows 1000000.
REQ-030 All digits 0 with blank_lz=1 -> digits 3-1 blank, digit0 shows 1000000; dp_en=4'b0100 -> dp=0 only during digit2's SHOW cycles, even though digit2 is blanked.
REQ-031 digit0 changed from 5 to 9 at cnt==4 of slot 0 -> seg=0010010 for the whole slot; 9 appears only at the next slot 0.
REQ-032 enable dropped in SHOW of slot 2 -> an=1111 two edges later and stays off; on re-enable, slot 0 starts with GAP.
REQ-033 Code 12 on digit1 -> seg=0111111; every cycle of a 1000-cycle random run -> at most one an bit low.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
package seg7_pkg;

   // Digit slot index: four digits need two bits.
   localparam int IDX_W = 2;
   typedef logic [IDX_W-1:0] idx_t;

   // Scan FSM states.
   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_GAP  = 2'd1,
      ST_SHOW = 2'd2
   } state_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // All anodes released (active low).
   localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational code-to-segment decoder; codes 10-15 render as a dash.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   // Table lookup from digit code to active-low segment pattern.
   always_comb begin
      seg_o = SEG_DASH;
      case (code_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_OFF  | scan disabled; all anodes and segments released
// ST_GAP  | start of a digit slot; display blanked to avoid ghosting
// ST_SHOW | current slot's digit driven from the slot snapshot
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GAP_CYC     = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic [3:0] dp_en,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   idx_t             idx_q;

   logic [3:0]       an_q;
   logic [6:0]       seg_q;
   logic             dp_q;

   // Per-slot snapshot, so mid-slot input changes never tear a digit.
   logic [3:0]       snap_code_q, snap_code_d;
   logic             snap_dp_q, snap_dp_d;
   logic             snap_blank_q, snap_blank_d;

   logic [6:0]       seg_dec;

   seg7_decoder u_dec (
      .code_i (snap_code_q),
      .seg_o  (seg_dec)
   );

   // Select the inputs for the slot about to start and decide leading-zero blanking.
   always_comb begin
      snap_code_d  = digit0;
      snap_dp_d    = dp_en[0];
      snap_blank_d = 1'b0;
      case (idx_q)
         2'd0: begin
            snap_code_d  = digit0;
            snap_dp_d    = dp_en[0];
            snap_blank_d = 1'b0;
         end
         2'd1: begin
            snap_code_d  = digit1;
            snap_dp_d    = dp_en[1];
            snap_blank_d = blank_lz && (digit3 == 4'd0) && (digit2 == 4'd0)
                           && (digit1 == 4'd0);
         end
         2'd2: begin
            snap_code_d  = digit2;
            snap_dp_d    = dp_en[2];
            snap_blank_d = blank_lz && (digit3 == 4'd0) && (digit2 == 4'd0);
         end
         default: begin
            snap_code_d  = digit3;
            snap_dp_d    = dp_en[3];
            snap_blank_d = blank_lz && (digit3 == 4'd0);
         end
      endcase
   end

   // Capture the slot snapshot on the first cycle of every slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_code_q  <= 4'd0;
         snap_dp_q    <= 1'b0;
         snap_blank_q <= 1'b0;
      end else if (cnt_q == '0) begin
         snap_code_q  <= snap_code_d;
         snap_dp_q    <= snap_dp_d;
         snap_blank_q <= snap_blank_d;
      end
   end

   // Scan FSM, slot counter, digit index and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         idx_q   <= '0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         if (state_q == ST_SHOW) begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= snap_blank_q ? SEG_BLANK : seg_dec;
            dp_q  <= ~snap_dp_q;
         end else begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
         end

         if (!enable) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  state_q <= ST_GAP;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end
               ST_GAP: begin
                  if (cnt_q == GAP_LAST) begin
                     state_q <= ST_SHOW;
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               ST_SHOW: begin
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_GAP;
                     cnt_q   <= '0;
                     idx_q   <= idx_q + idx_t'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= ST_OFF;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
